// File: rtl/kahan_pkg.sv
// Shared types for the Kahan adder-tree front end: element, gather FSM state and
// vector sequence tag.
package kahan_pkg;

   localparam int EXP_WIDTH  = 5;
   localparam int MANT_WIDTH = 2;
   localparam int BIT_WIDTH  = 1 + EXP_WIDTH + MANT_WIDTH;

   typedef logic signed [BIT_WIDTH-1:0] elem_t;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      ISSUE = 1'b1
   } gather_state_e;

   typedef logic [7:0] vec_id_t;

endpackage

// File: rtl/kahan_valid_delay.sv
// Fixed-depth valid+tag shift register that mirrors the adder tree's pipeline
// latency, so the tag leaves in the same cycle as the matching sum.
module kahan_valid_delay #(
   parameter int DEPTH = 8,
   parameter int TAG_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   output logic [TAG_W-1:0] tag_o
);

   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

   always_comb begin
      valid_d[0] = valid_i;
      tag_d[0]   = tag_i;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         tag_d[i]   = tag_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/kahan_vec_gather.sv
// Serial-to-parallel gather in front of the Kahan adder tree, with sum-valid tracking.
// Define KAHAN_GATHER_PAD_EN to let elem_last_i close a short, zero-padded vector.
module kahan_vec_gather
   import kahan_pkg::*;
#(
   parameter int  EXP_WIDTH_I  = 5,
   parameter int  MANT_WIDTH_I = 2,
   parameter int  ELEMS_COUNT  = 32,
   parameter int  TREE_LATENCY = 8,
   localparam int BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
   localparam int CNT_W        = $clog2(ELEMS_COUNT)
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic signed [BIT_WIDTH_I-1:0]            elem_i,
   input  logic                                     elem_valid_i,
   input  logic                                     elem_last_i,
   output logic                                     elem_ready_o,
   output logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0]  vec_o,
   output logic                                     vec_valid_o,
   output logic                                     sum_valid_o,
   output logic [7:0]                               vec_id_o
);

   gather_state_e                          state_q, state_d;
   logic [CNT_W:0]                         cnt_q, cnt_d;
   logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] buf_q, buf_d;
   logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] vec_q, vec_d;
   logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] issue_vec;
   logic                                   vec_valid_q, vec_valid_d;
   vec_id_t                                issue_id_q, issue_id_d;
   vec_id_t                                vec_tag_q, vec_tag_d;
   logic                                   accept;
   logic                                   last_elem;

   assign elem_ready_o = (state_q == FILL);
   assign accept       = elem_valid_i & elem_ready_o;

`ifdef KAHAN_GATHER_PAD_EN
   assign last_elem = elem_last_i;
   // cnt_q still holds the fill count during ISSUE; lanes beyond it read as zero.
   for (genvar gi = 0; gi < ELEMS_COUNT; gi++) begin : g_mask
      assign issue_vec[gi] = ((CNT_W+1)'(gi) < cnt_q) ? buf_q[gi] : '0;
   end
`else
   logic unused_last;
   assign unused_last = elem_last_i;
   assign last_elem   = 1'b0;
   assign issue_vec   = buf_q;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      vec_d       = vec_q;
      vec_valid_d = 1'b0;
      vec_tag_d   = vec_tag_q;
      issue_id_d  = issue_id_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               buf_d[cnt_q[CNT_W-1:0]] = elem_i;
               cnt_d                   = cnt_q + (CNT_W+1)'(1);
               if ((cnt_q == (CNT_W+1)'(ELEMS_COUNT-1)) || last_elem) begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            vec_d       = issue_vec;
            vec_valid_d = 1'b1;
            vec_tag_d   = issue_id_q;
            issue_id_d  = issue_id_q + 8'd1;
            buf_d       = '0;
            cnt_d       = '0;
            state_d     = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         buf_q       <= '0;
         vec_q       <= '0;
         vec_valid_q <= 1'b0;
         vec_tag_q   <= '0;
         issue_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         vec_q       <= vec_d;
         vec_valid_q <= vec_valid_d;
         vec_tag_q   <= vec_tag_d;
         issue_id_q  <= issue_id_d;
      end
   end

   assign vec_o       = vec_q;
   assign vec_valid_o = vec_valid_q;

   kahan_valid_delay #(
      .DEPTH (TREE_LATENCY),
      .TAG_W (8)
   ) u_valid_delay (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (vec_valid_q),
      .tag_i   (vec_tag_q),
      .valid_o (sum_valid_o),
      .tag_o   (vec_id_o)
   );

endmodule

// File: tb/tb_kahan_vec_gather.sv
// Self-checking bench for kahan_vec_gather (4 lanes, tree latency 3) against a
// cycle-scheduled behavioural model; works with or without KAHAN_GATHER_PAD_EN.
module tb_kahan_vec_gather;

   localparam int N = 4;
   localparam int L = 3;
   localparam int W = 8;

   typedef logic [N-1:0][W-1:0] vec_t;

   logic                clk = 1'b0;
   logic                rst_ni = 1'b1;
   logic signed [W-1:0] elem_i = '0;
   logic                elem_valid_i = 1'b0;
   logic                elem_last_i = 1'b0;
   logic                elem_ready_o;
   vec_t                vec_o;
   logic                vec_valid_o;
   logic                sum_valid_o;
   logic [7:0]          vec_id_o;

   always #5 clk = ~clk;

   kahan_vec_gather #(
      .EXP_WIDTH_I  (5),
      .MANT_WIDTH_I (2),
      .ELEMS_COUNT  (N),
      .TREE_LATENCY (L)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .elem_i       (elem_i),
      .elem_valid_i (elem_valid_i),
      .elem_last_i  (elem_last_i),
      .elem_ready_o (elem_ready_o),
      .vec_o        (vec_o),
      .vec_valid_o  (vec_valid_o),
      .sum_valid_o  (sum_valid_o),
      .vec_id_o     (vec_id_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A vector completed in cycle t appears on vec_o at t+2, ready drops in t+1,
   // and its sum pulse arrives at t+2+L carrying its sequence number.
   logic [W-1:0] partial[$];
   vec_t         ev_vec[int];
   logic [7:0]   ev_sum[int];
   logic [7:0]   m_id = 8'd0;
   int           m_issue_cyc = -1;
   vec_t         m_vec = '0;
   vec_t         m_v;
   bit           m_done;
   bit           exp_ready = 1'b1;
   bit           exp_vv = 1'b0;
   bit           exp_sv = 1'b0;
   logic [7:0]   exp_id = 8'd0;

   always @(posedge clk) begin
      if (!rst_ni) begin
         partial.delete();
         ev_vec.delete();
         ev_sum.delete();
         m_id        = 8'd0;
         m_issue_cyc = -1;
         m_vec       = '0;
         exp_ready   = 1'b1;
         exp_vv      = 1'b0;
         exp_sv      = 1'b0;
      end else begin
         if (elem_valid_i && exp_ready) begin
            partial.push_back(elem_i);
            m_done = (partial.size() == N);
`ifdef KAHAN_GATHER_PAD_EN
            if (elem_last_i) m_done = 1'b1;
`endif
            if (m_done) begin
               m_v = '0;
               foreach (partial[i]) m_v[i] = partial[i];
               ev_vec[cyc+2]   = m_v;
               ev_sum[cyc+2+L] = m_id;
               m_id            = m_id + 8'd1;
               m_issue_cyc     = cyc + 1;
               partial.delete();
            end
         end
         exp_ready = ((cyc + 1) != m_issue_cyc);
         exp_vv    = ev_vec.exists(cyc + 1);
         if (exp_vv) begin
            m_vec = ev_vec[cyc+1];
            ev_vec.delete(cyc + 1);
         end
         exp_sv = ev_sum.exists(cyc + 1);
         if (exp_sv) begin
            exp_id = ev_sum[cyc+1];
            ev_sum.delete(cyc + 1);
         end
      end
      cyc++;
   end

   // ---------------- per-cycle compare ----------------
   int         sum_seen = 0;
   logic [7:0] last_sum_id = 8'd0;
   bit         saw_wrap = 1'b0;

   always @(negedge clk) begin
      if (!rst_ni) begin
         check("rst_ready", elem_ready_o, 1);
         check("rst_vec_valid", vec_valid_o, 0);
         check("rst_vec", vec_o, 0);
         check("rst_sum_valid", sum_valid_o, 0);
         check("rst_vec_id", vec_id_o, 0);
      end else begin
         check("ready", elem_ready_o, exp_ready);
         check("vec_valid", vec_valid_o, exp_vv);
         check("vec_o", vec_o, m_vec);
         check("sum_valid", sum_valid_o, exp_sv);
         if (exp_sv) check("vec_id", vec_id_o, exp_id);
      end
      if (sum_valid_o) begin
         if (sum_seen > 0 && last_sum_id == 8'd255 && vec_id_o == 8'd0) saw_wrap = 1'b1;
         last_sum_id = vec_id_o;
         sum_seen++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] d, input bit last);
      bit done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
         @(negedge clk);
         elem_valid_i = 1'b1;
         elem_i       = d;
         elem_last_i  = last;
         if (elem_ready_o) begin
            done = 1'b1;
            @(posedge clk);
         end
      end
      check("send_accepted", done, 1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         elem_valid_i = 1'b0;
         elem_last_i  = 1'($urandom_range(0, 1));
         elem_i       = W'($urandom);
      end
   endtask

   task automatic expect_vec(input vec_t exp, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         elem_valid_i = 1'b0;
         elem_last_i  = 1'b0;
         if (vec_valid_o) begin
            seen = 1'b1;
            check(name, vec_o, exp);
         end
      end
      check({name, "_seen"}, seen, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ids[$];
      int         lows;
      bit         got;

      #1 rst_ni = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_ni = 1'b1;
      idle(2);

      // Test 1: 1,2,3,4 back-to-back with pinned timing
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         elem_valid_i = 1'b1;
         elem_last_i  = 1'b0;
         elem_i       = W'(i + 1);
         check("t1_ready_fill", elem_ready_o, 1);
      end
      @(negedge clk);
      elem_valid_i = 1'b0;
      check("t1_issue_ready_low", elem_ready_o, 0);
      @(negedge clk);
      check("t1_vec_valid", vec_valid_o, 1);
      check("t1_vec", vec_o, 32'h04030201);
      repeat (2) @(negedge clk);
      check("t1_sum_early", sum_valid_o, 0);
      @(negedge clk);
      check("t1_sum_valid", sum_valid_o, 1);
      check("t1_vec_id", vec_id_o, 0);

      // Test 2: continuous valid across 3 vectors
      lows = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (sum_valid_o) ids.push_back(vec_id_o);
         if (k < 15) begin
            if (!elem_ready_o) lows++;
            elem_valid_i = 1'b1;
            elem_last_i  = 1'b0;
            elem_i       = W'($urandom);
         end else begin
            elem_valid_i = 1'b0;
         end
      end
      check("t2_stall_cycles", lows, 3);
      check("t2_sum_count", ids.size(), 3);
      if (ids.size() == 3) begin
         check("t2_id0", ids[0], 1);
         check("t2_id1", ids[1], 2);
         check("t2_id2", ids[2], 3);
      end

      // Test 3: short vector terminated by elem_last_i
`ifdef KAHAN_GATHER_PAD_EN
      send(8'd7, 1'b0);
      send(8'd9, 1'b1);
      expect_vec(32'h00000907, "t3_pad_vec");
      send(8'd5, 1'b0);
      send(8'd6, 1'b0);
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      expect_vec(32'h02010605, "t3_next_vec");
`else
      send(8'd7, 1'b0);
      send(8'd9, 1'b1);
      send(8'd5, 1'b0);
      send(8'd6, 1'b0);
      expect_vec(32'h06050907, "t3_nopad_vec");
`endif

      // Test 4: reset mid-fill with a sum still in flight
      send(8'd11, 1'b0);
      send(8'd12, 1'b0);
      #1;
      elem_valid_i = 1'b0;
      rst_ni       = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_ni = 1'b1;
      send(8'd21, 1'b0);
      send(8'd22, 1'b0);
      send(8'd23, 1'b0);
      send(8'd24, 1'b0);
      expect_vec(32'h18171615, "t4_vec_after_reset");
      got = 1'b0;
      for (int k = 0; k < L + 4 && !got; k++) begin
         @(negedge clk);
         if (sum_valid_o) begin
            got = 1'b1;
            check("t4_vec_id", vec_id_o, 0);
         end
      end
      check("t4_sum_seen", got, 1);

      // Test 5: random traffic over 260 vectors to exercise the id wrap
      for (int v = 0; v < 260; v++) begin
         for (int e = 0; e < N; e++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(W'($urandom), ($urandom_range(0, 7) == 0));
         end
      end
      idle(3 * L + 10);
      check("t5_id_wrap", saw_wrap, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
